key_expand_visc: RTL and testbench

Sequential AES-128 key-schedule stage that sits directly upstream of the AES round datapath. It supplies the per-round key_in. The block expands a 128-bit cipher key into 11 round keys (rk0..rk10) at one round key per cycle and stores them in an internal bank. The cipher controller reads the bank through an indexed, registered read port while sequencing rounds.

---
 rtl/key_expand_visc.sv | 189 ++++++++++++++++++
 tb/tb_key_expand_visc.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/key_expand_visc.sv
// AES-128 key schedule: expands a cipher key into rk0..rk10 at one round key per
// cycle into an internal bank, read back through a registered indexed port.

module aes_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            acc = acc ^ (b[i] ? x : 8'h00);
            x   = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // Multiplicative inverse as x^254; zero maps to zero for free.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, x240;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
        x15  = gf_mul(x12, x3);
        x240 = gf_mul(x15, x15);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        return gf_mul(gf_mul(x240, x12), x2);
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    // Combinational byte substitution.
    always_comb begin
        dout = affine(gf_inv(din));
    end

endmodule

module key_expand_visc #(
    parameter int NUM_ROUNDS = 10,
    parameter int IDX_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [127:0]     key_in,
    output logic             busy,
    output logic             keys_valid,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [127:0]     rd_key
);

    if (NUM_ROUNDS != 10) begin : g_bad_rounds
        $fatal(1, "key_expand_visc supports only NUM_ROUNDS=10 (AES-128)");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_READY  = 2'd2
    } state_t;

    state_t       state_r;
    state_t       next_state_s;
    logic         accept_s;
    logic         step_s;
    logic         last_s;
    logic [3:0]   counter_r;
    logic [7:0]   rcon_r;
    logic [127:0] work_r;
    logic [127:0] bank_r [0:NUM_ROUNDS];
    logic [31:0]  rot_s;
    logic [31:0]  sub_s;
    logic [31:0]  t_s;
    logic [31:0]  n0_s, n1_s, n2_s, n3_s;
    logic [127:0] next_key_s;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    assign rot_s = {work_r[23:0], work_r[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_subword
        aes_sbox u_sbox (
            .din  (rot_s[8*b +: 8]),
            .dout (sub_s[8*b +: 8])
        );
    end

    // One key-schedule round on the working key.
    always_comb begin
        t_s        = sub_s ^ {rcon_r, 24'h000000};
        n0_s       = work_r[127:96] ^ t_s;
        n1_s       = work_r[95:64]  ^ n0_s;
        n2_s       = work_r[63:32]  ^ n1_s;
        n3_s       = work_r[31:0]   ^ n2_s;
        next_key_s = {n0_s, n1_s, n2_s, n3_s};
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next state and datapath strobes; start during EXPAND is dropped.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        step_s       = 1'b0;
        last_s       = 1'b0;
        case (state_r)
            ST_IDLE, ST_READY: begin
                if (start) begin
                    accept_s     = 1'b1;
                    next_state_s = ST_EXPAND;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_EXPAND: begin
                step_s = 1'b1;
                if (counter_r == 4'(NUM_ROUNDS)) begin
                    last_s       = 1'b1;
                    next_state_s = ST_READY;
                end else begin
                    next_state_s = ST_EXPAND;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Expansion datapath, round-key bank and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter_r  <= 4'd0;
            rcon_r     <= 8'h01;
            work_r     <= 128'h0;
            busy       <= 1'b0;
            keys_valid <= 1'b0;
            for (int i = 0; i <= NUM_ROUNDS; i++) begin
                bank_r[i] <= 128'h0;
            end
        end else if (accept_s) begin
            bank_r[0]  <= key_in;
            work_r     <= key_in;
            counter_r  <= 4'd1;
            rcon_r     <= 8'h01;
            busy       <= 1'b1;
            keys_valid <= 1'b0;
        end else if (step_s) begin
            bank_r[counter_r] <= next_key_s;
            work_r            <= next_key_s;
            counter_r         <= counter_r + 4'd1;
            rcon_r            <= xtime(rcon_r);
            if (last_s) begin
                busy       <= 1'b0;
                keys_valid <= 1'b1;
            end
        end
    end

    // Registered read port; the bank is read before any same-edge write lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_key <= 128'h0;
        end else if (rd_idx <= IDX_W'(NUM_ROUNDS)) begin
            rd_key <= bank_r[rd_idx];
        end else begin
            rd_key <= 128'h0;
        end
    end

endmodule

// File: tb/tb_key_expand_visc.sv
// Self-checking bench for key_expand_visc: FIPS-197 and zero-key vectors, random
// keys against a word-oriented key-schedule model, restart, reset and read port.

module tb_key_expand_visc;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         keys_valid;
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;

    int n_checks;
    int n_fail;

    logic [7:0]   sbox_t   [0:255];
    logic [127:0] exp_bank [0:10];
    logic [127:0] new_bank [0:10];

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    key_expand_visc #(.NUM_ROUNDS(10), .IDX_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .key_in     (key_in),
        .busy       (busy),
        .keys_valid (keys_valid),
        .rd_idx     (rd_idx),
        .rd_key     (rd_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Carry-less multiply then reduce modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = 15'h0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ (15'(a) << i);
        end
        for (int i = 14; i >= 8; i--) begin
            if (p[i]) p = p ^ (15'h011b << (i - 8));
        end
        return p[7:0];
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        logic [15:0] d;
        d = {b, b} << k;
        return d[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc [0:9];
        rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
                t = t ^ {rc[i/4 - 1], 24'h0};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) new_bank[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic read_chk(input string tag, input int idx, input logic [127:0] exp);
        rd_idx = 4'(idx);
        @(posedge clk);
        #1;
        chk(tag, rd_key, exp);
    endtask

    // Full expansion; ign1/ign2 inject ignored starts, peek probes a read-during-write.
    task automatic do_expand(input logic [127:0] key, input int ign1, input int ign2,
                             input int peek);
        model_expand(key);
        start  = 1'b1;
        key_in = key;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", 128'(busy), 128'(1));
        chk("valid_after_start", 128'(keys_valid), 128'(0));
        for (int c = 1; c <= 10; c++) begin
            if (c == ign1 || c == ign2) begin
                start  = 1'b1;
                key_in = ~key;
            end
            if (c == peek) rd_idx = 4'(peek);
            @(posedge clk);
            #1;
            start = 1'b0;
            chk($sformatf("busy_c%0d", c), 128'(busy), 128'(c < 10));
            chk($sformatf("valid_c%0d", c), 128'(keys_valid), 128'(c == 10));
            if (c == peek) chk("rbw_old", rd_key, exp_bank[peek]);
            if (c == peek + 1) chk("rbw_new", rd_key, new_bank[peek]);
        end
        for (int r = 0; r < 11; r++) exp_bank[r] = new_bank[r];
    endtask

    task automatic check_bank(input string tag);
        for (int r = 0; r < 11; r++) read_chk($sformatf("%s_rk%0d", tag, r), r, exp_bank[r]);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        build_sbox();
        for (int r = 0; r < 11; r++) exp_bank[r] = 128'h0;
        rst    = 1'b1;
        start  = 1'b0;
        key_in = 128'h0;
        rd_idx = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 128'(busy), 128'(0));
        chk("reset_valid", 128'(keys_valid), 128'(0));
        chk("reset_rd_key", rd_key, 128'h0);
        @(negedge clk);
        rst = 1'b0;

        // FIPS-197 key from IDLE
        do_expand(FIPS_KEY, 0, 0, -5);
        read_chk("fips_rk1", 1, FIPS_RK1);
        read_chk("fips_rk10", 10, FIPS_RK10);
        read_chk("fips_rk0", 0, FIPS_KEY);
        check_bank("fips");

        // zero key restarted from READY, probing rk4 as it is overwritten
        do_expand(128'h0, 0, 0, 4);
        read_chk("zero_rk1", 1, ZERO_RK1);
        read_chk("zero_rk10", 10, ZERO_RK10);
        check_bank("zero");

        // FIPS key again with starts pulsed mid-expansion
        do_expand(FIPS_KEY, 3, 7, -5);
        read_chk("ign_rk1", 1, FIPS_RK1);
        read_chk("ign_rk10", 10, FIPS_RK10);
        check_bank("ign");

        // random keys
        for (int k = 0; k < 3; k++) begin
            do_expand({$urandom, $urandom, $urandom, $urandom}, 0, 0, 2 + 3 * k);
            check_bank($sformatf("rnd%0d", k));
        end

        // asynchronous reset mid-expansion
        rd_idx = 4'd0;
        start  = 1'b1;
        key_in = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_busy", 128'(busy), 128'(0));
        chk("arst_valid", 128'(keys_valid), 128'(0));
        chk("arst_rd_key", rd_key, 128'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int r = 0; r < 11; r++) exp_bank[r] = 128'h0;
        read_chk("arst_rk3", 3, 128'h0);
        chk("arst_idle_valid", 128'(keys_valid), 128'(0));
        do_expand({$urandom, $urandom, $urandom, $urandom}, 0, 0, 3);
        check_bank("post_rst");

        // read-port sweep including out-of-range indices
        for (int i = 0; i < 16; i++) begin
            read_chk($sformatf("sweep%0d", i), i, (i <= 10) ? exp_bank[i] : 128'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
